// File: rtl/run_stream_source.sv
// Opcode-tagged host word decoder feeding the network core: NOM transfers, counted RUN steps, one-cycle CLR.
// Optional RUN_STREAM_SOURCE_HOLD_EN: RUN steps replay the last NOM payload instead of zeros.
module run_stream_source #(
    parameter int NUM_INP      = 8,
    parameter int CHARGE_WIDTH = 8,
    parameter int RUN_WIDTH    = 16,
    parameter int OPC_WIDTH    = 2,
    localparam int SRC_WIDTH   = OPC_WIDTH + NUM_INP * CHARGE_WIDTH
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic                            src_valid,
    output logic                            src_ready,
    input  logic [SRC_WIDTH-1:0]            src,
    input  logic                            net_ready,
    output logic                            net_valid,
    output logic                            net_last,
    output logic                            net_rst,
    output logic [NUM_INP*CHARGE_WIDTH-1:0] net_inp,
    output logic                            err_opc
);

    localparam int DATA_W = NUM_INP * CHARGE_WIDTH;

    localparam logic [OPC_WIDTH-1:0] OPC_NOM = OPC_WIDTH'(0);
    localparam logic [OPC_WIDTH-1:0] OPC_RUN = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] OPC_CLR = OPC_WIDTH'(2);

    localparam logic [RUN_WIDTH-1:0] CNT_ONE = RUN_WIDTH'(1);
    localparam logic [RUN_WIDTH-1:0] CNT_TWO = RUN_WIDTH'(2);

    typedef enum logic [1:0] {S_IDLE, S_NOM, S_RUN, S_CLR} state_t;

    state_t                 state;
    logic [RUN_WIDTH-1:0]   cnt;
    logic [OPC_WIDTH-1:0]   opc;
    logic [DATA_W-1:0]      payload;
    logic [RUN_WIDTH-1:0]   run_count;
    logic [DATA_W-1:0]      run_vec;
    logic                   accept;
    logic                   done;

    assign opc       = src[SRC_WIDTH-1 -: OPC_WIDTH];
    assign payload   = src[DATA_W-1:0];
    assign run_count = payload[RUN_WIDTH-1:0];

    // A new word may only land when the current transfer is finishing this cycle.
    assign src_ready = (state == S_IDLE)
                    || (state == S_NOM && net_ready)
                    || (state == S_RUN && net_ready && cnt == CNT_ONE);
    assign accept    = src_valid && src_ready;
    assign done      = net_valid && net_ready;

`ifdef RUN_STREAM_SOURCE_HOLD_EN
    logic [DATA_W-1:0] hold;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hold <= '0;
        end else if (accept && opc == OPC_NOM) begin
            hold <= payload;
        end else if (accept && opc == OPC_CLR) begin
            hold <= '0;
        end
    end

    assign run_vec = hold;
`else
    assign run_vec = '0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            net_inp   <= '0;
            net_valid <= 1'b0;
            net_last  <= 1'b0;
            net_rst   <= 1'b0;
            err_opc   <= 1'b0;
        end else if (accept) begin
            if (opc == OPC_NOM) begin
                state     <= S_NOM;
                net_inp   <= payload;
                net_valid <= 1'b1;
                net_last  <= 1'b0;
            end else if (opc == OPC_RUN) begin
                // A zero count is swallowed so cnt never holds 0 while running.
                if (run_count != '0) begin
                    state     <= S_RUN;
                    cnt       <= run_count;
                    net_inp   <= run_vec;
                    net_valid <= 1'b1;
                    net_last  <= (run_count == CNT_ONE);
                end else begin
                    state     <= S_IDLE;
                    net_valid <= 1'b0;
                    net_last  <= 1'b0;
                end
            end else if (opc == OPC_CLR) begin
                state     <= S_CLR;
                net_rst   <= 1'b1;
                net_valid <= 1'b0;
                net_last  <= 1'b0;
            end else begin
                state     <= S_IDLE;
                err_opc   <= 1'b1;
                net_valid <= 1'b0;
                net_last  <= 1'b0;
            end
        end else if (done) begin
            if (state == S_RUN && cnt != CNT_ONE) begin
                cnt      <= cnt - CNT_ONE;
                net_last <= (cnt == CNT_TWO);
            end else begin
                state     <= S_IDLE;
                net_valid <= 1'b0;
                net_last  <= 1'b0;
            end
        end else if (state == S_CLR) begin
            state   <= S_IDLE;
            net_rst <= 1'b0;
        end
    end

endmodule

// File: doc/run_stream_source.md
Name: run_stream_source

Overview:
- Parametrised successor to the single-cycle network source.
- Decodes opcode-tagged words from the host stream into network input transfers.
- Adds a RUN opcode: N idle network timesteps from one source word, with a live run counter and net_last marking the final step.
- Adds a registered one-cycle synchronous network clear, fully registered outputs, and sticky bad-opcode reporting.
- Sits between the host deserialiser and the network core.

Parameters:
- NUM_INP, 8: number of network input channels.
- CHARGE_WIDTH, 8: signed charge width per channel.
- RUN_WIDTH, 16: run-count width; must be <= NUM_INP*CHARGE_WIDTH.
- OPC_WIDTH, 2: opcode field width; must be >= 2.
- Derived: SRC_WIDTH = OPC_WIDTH + NUM_INP*CHARGE_WIDTH.

Ports:
- clk  input  1  clock; all state on rising edge.
- arst  input  1  reset, asynchronous, active-high.
- src_valid  input  1  source word valid.
- src_ready  output  1  source word accepted when src_valid && src_ready.
- src  input  SRC_WIDTH  opcode in MSBs; payload below.
- net_ready  input  1  network accepts a transfer.
- net_valid  output  1  transfer valid.
- net_last  output  1  final transfer of a RUN.
- net_rst  output  1  one-cycle synchronous network clear.
- net_inp  output  NUM_INP*CHARGE_WIDTH  channel i at bits [(NUM_INP-1-i)*CHARGE_WIDTH +: CHARGE_WIDTH]; channel 0 is the payload MSB slice.
- err_opc  output  1  sticky flag: reserved opcode seen.

Behaviour:
- Opcodes: 0 NOM, 1 RUN, 2 CLR, 3 and up reserved.
- NOM payload: packed signed charges.
- RUN payload: unsigned count in the low RUN_WIDTH bits; upper payload bits ignored.
- State machine:
  - S_IDLE: output empty.
  - S_NOM: one transfer pending.
  - S_RUN: counted transfers pending.
  - S_CLR: clear pulse.
- src_ready = S_IDLE || (S_NOM && net_ready) || (S_RUN && net_ready && cnt==1). It is a combinational function of state and net_ready only, never of src_valid.
- Transfer completes on net_valid && net_ready.
- On accept, the next state depends on the opcode:
  - NOM: -> S_NOM; net_inp loaded from payload; net_last=0.
  - RUN with count>0: -> S_RUN; cnt=count; net_inp=0.
  - RUN with count=0: consumed, no transfer, -> S_IDLE.
  - CLR: -> S_CLR.
  - Reserved: consumed, dropped, err_opc<=1, -> S_IDLE.
- With no accept, each transfer completion moves S_NOM or S_RUN (cnt==1) -> S_IDLE.
- S_RUN with a completion and cnt>1: cnt decrements; net_valid stays high.
- net_last = S_RUN && cnt==1.
- net_valid = S_NOM || S_RUN. Registered; no combinational path src_valid->net_valid.
- Latency: accept at edge k -> net_valid high from k+1.
- Throughput: back-to-back NOM at 1 word/cycle while net_ready=1.
- S_CLR lasts exactly one cycle with net_rst=1, net_valid=0, src_ready=0, then -> S_IDLE.
  - CLR arriving while a transfer is pending is accepted only after that transfer completes, so a clear never truncates a transfer.
- Backpressure: net_inp, net_last and cnt are held while net_valid && !net_ready.
- Count wrap: cnt is never loaded with 0. A count of 2^RUN_WIDTH-1 produces exactly that many transfers.
- Reset (arst=1, any state, including mid-run): state S_IDLE, cnt=0, net_inp=0, net_valid=0, net_last=0, net_rst=0, err_opc=0, hold register=0.
  - src_ready=1 once arst deasserts.
  - No residual transfers after release.
- err_opc clears only on arst.

Optional Feature:
- Macro RUN_STREAM_SOURCE_HOLD_EN.
- When defined:
  - A hold register captures each accepted NOM payload.
  - RUN steps drive the held vector on net_inp instead of zeros.
  - CLR and arst zero the hold register.
- When undefined:
  - No hold register is synthesised.
  - RUN steps drive all-zero net_inp.

Test Plan (NUM_INP=2, CHARGE_WIDTH=8, RUN_WIDTH=8, OPC_WIDTH=2, SRC_WIDTH=18):
- NOM 0x005FB, net_ready=1 -> next cycle net_valid=1, ch0=+5, ch1=-5, net_last=0; three back-to-back NOMs give three consecutive transfers.
- RUN count 3, net_ready low for 2 cycles after the first transfer -> exactly 3 zero transfers; net_last only on the 3rd; outputs stable while stalled.
- CLR -> net_rst=1 for exactly one cycle; net_valid=0 and src_ready=0 that cycle; src_ready=1 the next.
- RUN count 0 then NOM 0x00102 -> no transfer for the RUN; NOM transfer (ch0=1, ch1=2) appears 2 cycles after the RUN is accepted.
- Opcode 3 word -> no transfer, err_opc=1 and stays 1 across later NOM and CLR until arst.
- arst pulsed with 5 RUN steps remaining -> all outputs 0 during reset; after release, zero transfers until a new word.
